// File: rtl/control_riesgos_pkg.sv
// Shared types and constants for the decode-stage hazard control unit.
package control_riesgos_pkg;

    localparam int REG_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } estado_t;

    // Control word loaded into Reg_Exe when a bubble is inserted.
    typedef struct packed {
        logic we;
        logic mem_re;
        logic mem_we;
        logic re_a;
        logic re_b;
    } ctrl_exe_t;

    localparam ctrl_exe_t NOP_CTRL = '0;

endpackage

// File: rtl/control_riesgos_contador_sat.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module contador_sat #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/control_riesgos.sv
// Load-use hazard stall and taken-branch flush control for the decode stage,
// with saturating stall/flush profiling counters.
module control_riesgos
    import control_riesgos_pkg::*;
#(
    parameter int LOAD_STALL  = 1,
    parameter int CNT_W       = 16,
    parameter int FLUSH_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_W-1:0]       Ra_F_Reg,
    input  logic [REG_W-1:0]       Rb_F_Reg,
    input  logic                   RE_A_F_Reg,
    input  logic                   RE_B_F_Reg,
    input  logic [REG_W-1:0]       Robj_Reg_Exe,
    input  logic                   mem_RE_Reg_Exe,
    input  logic                   WE_Reg_Exe,
    input  logic                   branch_taken,
    output logic                   stall_F,
    output logic                   stall_F_Reg,
    output logic                   bubble_Reg_Exe,
    output logic                   flush_F_Reg,
    output logic                   in_stall,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    localparam int CW = 3;

    estado_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hz;

    assign hz = mem_RE_Reg_Exe & WE_Reg_Exe &
                ((RE_A_F_Reg & (Ra_F_Reg == Robj_Reg_Exe)) |
                 (RE_B_F_Reg & (Rb_F_Reg == Robj_Reg_Exe)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The detection cycle is the first stall cycle, so STALL covers LOAD_STALL-1 more.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!branch_taken && hz && (LOAD_STALL > 1)) begin
                    state_d = STALL;
                    cnt_d   = CW'(LOAD_STALL - 1);
                end
            end
            STALL: begin
                if (branch_taken) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1))
                        state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_F        = 1'b0;
        stall_F_Reg    = 1'b0;
        bubble_Reg_Exe = 1'b0;
        flush_F_Reg    = 1'b0;
        if (rst_n) begin
            if (branch_taken) begin
                flush_F_Reg    = 1'b1;
                bubble_Reg_Exe = 1'b1;
            end else if ((state_q == STALL) || hz) begin
                stall_F        = 1'b1;
                stall_F_Reg    = 1'b1;
                bubble_Reg_Exe = 1'b1;
            end
        end
    end

    assign in_stall = (state_q == STALL);

    contador_sat #(.W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_F),
        .q     (stall_cycles)
    );

    contador_sat #(.W(FLUSH_CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush_F_Reg),
        .q     (flush_count)
    );

endmodule

// File: tb/tb_control_riesgos.sv
// Directed bench: one instance with LOAD_STALL=1 (d1) and one with LOAD_STALL=3 (d3), shared inputs.
module tb_control_riesgos;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ra, rb, robj;
    logic       re_a, re_b, mem_re, we, br;

    logic        d1_sf, d1_sfr, d1_bub, d1_fl, d1_ins;
    logic [15:0] d1_sc;
    logic [7:0]  d1_fc;
    logic        d3_sf, d3_sfr, d3_bub, d3_fl, d3_ins;
    logic [15:0] d3_sc;
    logic [7:0]  d3_fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_riesgos #(.LOAD_STALL(1), .CNT_W(16), .FLUSH_CNT_W(8)) d1 (
        .clk(clk), .rst_n(rst_n), .Ra_F_Reg(ra), .Rb_F_Reg(rb),
        .RE_A_F_Reg(re_a), .RE_B_F_Reg(re_b), .Robj_Reg_Exe(robj),
        .mem_RE_Reg_Exe(mem_re), .WE_Reg_Exe(we), .branch_taken(br),
        .stall_F(d1_sf), .stall_F_Reg(d1_sfr), .bubble_Reg_Exe(d1_bub),
        .flush_F_Reg(d1_fl), .in_stall(d1_ins), .stall_cycles(d1_sc),
        .flush_count(d1_fc)
    );

    control_riesgos #(.LOAD_STALL(3), .CNT_W(16), .FLUSH_CNT_W(8)) d3 (
        .clk(clk), .rst_n(rst_n), .Ra_F_Reg(ra), .Rb_F_Reg(rb),
        .RE_A_F_Reg(re_a), .RE_B_F_Reg(re_b), .Robj_Reg_Exe(robj),
        .mem_RE_Reg_Exe(mem_re), .WE_Reg_Exe(we), .branch_taken(br),
        .stall_F(d3_sf), .stall_F_Reg(d3_sfr), .bubble_Reg_Exe(d3_bub),
        .flush_F_Reg(d3_fl), .in_stall(d3_ins), .stall_cycles(d3_sc),
        .flush_count(d3_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks land mid-cycle.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic ea, input logic [3:0] b, input logic eb,
                         input logic [3:0] o, input logic mr, input logic w, input logic t);
        ra = a; re_a = ea; rb = b; re_b = eb; robj = o; mem_re = mr; we = w; br = t;
    endtask

    task automatic idle_in();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_hz();
        drive(4'd1, 1'b1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        #1;
        chk("rst_d1_sf", d1_sf, 0);
        chk("rst_d3_bub", d3_bub, 0);
        repeat (2) next_cyc();
        chk("rst_d1_sc", d1_sc, 0);
        chk("rst_d1_fc", d1_fc, 0);
        chk("rst_d3_ins", d3_ins, 0);
        rst_n = 1'b1;

        // Load-use on Ra: d1 stalls 1 cycle, d3 stalls 3
        next_cyc(); load_hz(); #3;
        chk("t1_d1_sf", d1_sf, 1);
        chk("t1_d1_sfr", d1_sfr, 1);
        chk("t1_d1_bub", d1_bub, 1);
        chk("t1_d1_fl", d1_fl, 0);
        chk("t1_d1_ins", d1_ins, 0);
        chk("t1_d3_sf", d3_sf, 1);
        chk("t1_d3_ins", d3_ins, 0);
        next_cyc(); drive(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); #3;
        chk("t2_d1_sf", d1_sf, 0);
        chk("t2_d1_ins", d1_ins, 0);
        chk("t2_d1_sc", d1_sc, 1);
        chk("t2_d3_sf", d3_sf, 1);
        chk("t2_d3_ins", d3_ins, 1);
        next_cyc(); #3;
        chk("t3_d3_sf", d3_sf, 1);
        chk("t3_d3_bub", d3_bub, 1);
        chk("t3_d3_ins", d3_ins, 1);
        next_cyc(); #3;
        chk("t4_d3_sf", d3_sf, 0);
        chk("t4_d3_ins", d3_ins, 0);
        chk("t4_d3_sc", d3_sc, 3);
        chk("t4_d1_sc", d1_sc, 1);

        // ALU write to R1 in Exe: forwarding covers it
        next_cyc(); drive(4'd1, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0); #3;
        chk("alu_d1_sf", d1_sf, 0);
        chk("alu_d1_bub", d1_bub, 0);
        chk("alu_d3_sf", d3_sf, 0);

        // Rb matches but decode does not read it (store data)
        next_cyc(); drive(4'd2, 1'b1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0); #3;
        chk("st_d1_sf", d1_sf, 0);
        chk("st_d3_sf", d3_sf, 0);

        // Rb read enabled: hazard on source B
        next_cyc(); drive(4'd2, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0); #3;
        chk("rb_d1_sf", d1_sf, 1);
        next_cyc(); idle_in();
        repeat (2) next_cyc();

        // Register 0 compares like any other
        next_cyc(); drive(4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0); #3;
        chk("r0_d1_sf", d1_sf, 1);
        next_cyc(); idle_in(); #3;
        chk("r0_d1_sc", d1_sc, 3);
        repeat (2) next_cyc();

        // Taken branch overrides hazard
        next_cyc(); load_hz(); br = 1'b1; #3;
        chk("br_d1_fl", d1_fl, 1);
        chk("br_d1_bub", d1_bub, 1);
        chk("br_d1_sf", d1_sf, 0);
        chk("br_d1_sfr", d1_sfr, 0);
        chk("br_d3_sf", d3_sf, 0);
        next_cyc(); idle_in(); #3;
        chk("br_d1_fc", d1_fc, 1);
        chk("br_d1_sc", d1_sc, 3);
        chk("br_d1_fl_off", d1_fl, 0);
        chk("br_d3_ins", d3_ins, 0);

        // Branch while d3 is in STALL
        next_cyc(); load_hz(); #3;
        chk("bs_d3_sf0", d3_sf, 1);
        next_cyc(); idle_in(); br = 1'b1; #3;
        chk("bs_d3_ins", d3_ins, 1);
        chk("bs_d3_fl", d3_fl, 1);
        chk("bs_d3_sf", d3_sf, 0);
        chk("bs_d3_bub", d3_bub, 1);
        next_cyc(); idle_in(); #3;
        chk("bs_d3_ins_off", d3_ins, 0);
        chk("bs_d3_sf_off", d3_sf, 0);
        chk("bs_d3_fc", d3_fc, 2);
        chk("bs_d3_sc", d3_sc, 10);

        // Reset in the second stall cycle aborts immediately
        next_cyc(); load_hz(); #3;
        next_cyc(); idle_in(); #3;
        chk("rs_d3_sf_pre", d3_sf, 1);
        chk("rs_d3_ins_pre", d3_ins, 1);
        #1 rst_n = 1'b0; #1;
        chk("rs_d3_sf", d3_sf, 0);
        chk("rs_d3_bub", d3_bub, 0);
        chk("rs_d3_ins", d3_ins, 0);
        chk("rs_d3_sc", d3_sc, 0);
        chk("rs_d3_fc", d3_fc, 0);
        chk("rs_d1_sc", d1_sc, 0);
        next_cyc(); rst_n = 1'b1; #3;
        chk("rs_post_sf", d3_sf, 0);
        chk("rs_post_ins", d3_ins, 0);
        next_cyc(); #3;
        chk("rs_post2_sf", d3_sf, 0);
        chk("rs_post2_sc", d3_sc, 0);

        // Saturation: continuous hazard on d1 stalls every cycle
        next_cyc(); load_hz();
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", d1_sc, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_ffff", d1_sc, 16'hFFFF);
        chk("sat_sf", d1_sf, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
